// File: rtl/mem_access_unit.sv
// -----------------------------------------------------------------------------
// mem_access_unit
// Data-memory stage of the MIPS datapath. Uses the ALU result as the byte
// address and register B as store data. Performs byte, halfword and word loads
// and stores on an internal word-addressed RAM with big-endian byte lanes.
// Loads are sign- or zero-extended. Illegal (misaligned or size=11) accesses
// are flagged and not performed. A req/done handshake paces the controller.
//
// Optional feature macro: MEM_WAIT_STATES_EN
//   defined   -> every access is stretched by WAIT_CYCLES busy cycles
//   undefined -> fixed latency, done one cycle after the accept edge
//
// Parameters:
//   DEPTH_WORDS  RAM depth in 32-bit words (power of two, >= 2)
//   WAIT_CYCLES  extra busy cycles per access (1..15), macro builds only
//
// Ports:
//   i_clk       rising-edge clock
//   i_rst       synchronous active-high reset
//   i_req       access request, sampled while accepting (IDLE or RESP)
//   i_we        1 = store, 0 = load
//   i_size      00 byte, 01 halfword, 10 word, 11 illegal
//   i_sign_ext  loads only: 1 = sign-extend, 0 = zero-extend
//   i_addr      byte address; bits above the RAM index are ignored
//   i_wdata     store data; low byte/half used for sub-word stores
//   o_rdata     load result, valid while o_done = 1, held afterwards
//   o_done      one-cycle completion pulse
//   o_busy      access in progress, i_req ignored
//   o_misalign  valid with o_done; access was illegal and not performed
// -----------------------------------------------------------------------------
module mem_access_unit #(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_req,
  input  logic        i_we,
  input  logic [1:0]  i_size,
  input  logic        i_sign_ext,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_rdata,
  output logic        o_done,
  output logic        o_busy,
  output logic        o_misalign
);

  localparam int AW = $clog2(DEPTH_WORDS);

  // S_ACC is the single busy cycle just before the execute edge; the edge
  // leaving S_ACC (into S_RESP) performs the RAM write and registers rdata.
`ifdef MEM_WAIT_STATES_EN
  typedef enum logic [1:0] {S_IDLE, S_ACC, S_RESP, S_WAIT} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_ACC, S_RESP} state_t;
  localparam int unused_wait_cycles = WAIT_CYCLES;
`endif

  state_t          r_state;
  logic            r_we;
  logic [1:0]      r_size;
  logic            r_sext;
  logic [AW+1:0]   r_addr;
  logic [31:0]     r_wdata;
  logic [31:0]     r_rdata;
  logic            r_done;
  logic            r_busy;
  logic            r_misalign;
`ifdef MEM_WAIT_STATES_EN
  logic [3:0]      r_cnt;
`endif

  logic [31:0]     r_mem [DEPTH_WORDS];

  logic            w_exec;
  logic [AW-1:0]   w_idx;
  logic [1:0]      w_off;
  logic            w_misalign;
  logic [31:0]     w_rword;
  logic [3:0]      w_be;
  logic [31:0]     w_wword;
  logic [7:0]      w_byte;
  logic [15:0]     w_half;
  logic [31:0]     w_ld;
  logic            w_unused_addr;

  // Upper address bits only alias; they never reach the RAM.
  assign w_unused_addr = ^i_addr[31:AW+2];

  assign w_idx   = r_addr[AW+1:2];
  assign w_off   = r_addr[1:0];
  assign w_rword = r_mem[w_idx];
  // Reset on the execute edge cancels the access, including its write.
  assign w_exec  = (r_state == S_ACC) && !i_rst;

  assign w_misalign = (r_size == 2'b11) ||
                      ((r_size == 2'b01) && r_addr[0]) ||
                      ((r_size == 2'b10) && (r_addr[1:0] != 2'b00));

  // Store lane enables (bit 3 = bits 31:24, big-endian) and replicated data,
  // so each enabled lane simply takes its own slice of w_wword.
  always_comb begin
    w_be    = 4'b0000;
    w_wword = 32'h0;
    case (r_size)
      2'b00: begin
        w_be    = 4'b1000 >> w_off;
        w_wword = {4{r_wdata[7:0]}};
      end
      2'b01: begin
        w_be    = w_off[1] ? 4'b0011 : 4'b1100;
        w_wword = {2{r_wdata[15:0]}};
      end
      2'b10: begin
        w_be    = 4'b1111;
        w_wword = r_wdata;
      end
      default: begin
        w_be    = 4'b0000;
        w_wword = 32'h0;
      end
    endcase
    if (w_misalign) w_be = 4'b0000;
  end

  // Load lane select, right-justify, then extend.
  assign w_half = w_off[1] ? w_rword[15:0] : w_rword[31:16];

  always_comb begin
    w_byte = 8'h0;
    case (w_off)
      2'b00:   w_byte = w_rword[31:24];
      2'b01:   w_byte = w_rword[23:16];
      2'b10:   w_byte = w_rword[15:8];
      default: w_byte = w_rword[7:0];
    endcase
  end

  always_comb begin
    w_ld = 32'h0;
    if (!w_misalign) begin
      case (r_size)
        2'b00:   w_ld = r_sext ? {{24{w_byte[7]}}, w_byte} : {24'h0, w_byte};
        2'b01:   w_ld = r_sext ? {{16{w_half[15]}}, w_half} : {16'h0, w_half};
        2'b10:   w_ld = w_rword;
        default: w_ld = 32'h0;
      endcase
    end
  end

  // RAM array: not reset, byte-lane write on the execute edge.
  always_ff @(posedge i_clk) begin
    if (w_exec && r_we) begin
      for (int i = 0; i < 4; i++) begin
        if (w_be[i]) r_mem[w_idx][i*8 +: 8] <= w_wword[i*8 +: 8];
      end
    end
  end

  // Control FSM with registered outputs.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= S_IDLE;
      r_done     <= 1'b0;
      r_busy     <= 1'b0;
      r_rdata    <= 32'h0;
      r_misalign <= 1'b0;
      r_we       <= 1'b0;
      r_size     <= 2'b00;
      r_sext     <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= 32'h0;
`ifdef MEM_WAIT_STATES_EN
      r_cnt      <= 4'h0;
`endif
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE, S_RESP: begin
          if (i_req) begin
            r_we    <= i_we;
            r_size  <= i_size;
            r_sext  <= i_sign_ext;
            r_addr  <= i_addr[AW+1:0];
            r_wdata <= i_wdata;
            r_busy  <= 1'b1;
`ifdef MEM_WAIT_STATES_EN
            r_state <= S_WAIT;
            r_cnt   <= 4'(WAIT_CYCLES - 1);
`else
            r_state <= S_ACC;
`endif
          end else begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        end
`ifdef MEM_WAIT_STATES_EN
        S_WAIT: begin
          r_busy <= 1'b1;
          if (r_cnt == 4'h0) r_state <= S_ACC;
          else               r_cnt   <= r_cnt - 4'h1;
        end
`endif
        S_ACC: begin
          r_state    <= S_RESP;
          r_busy     <= 1'b0;
          r_done     <= 1'b1;
          r_rdata    <= w_ld;
          r_misalign <= w_misalign;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign o_rdata    = r_rdata;
  assign o_done     = r_done;
  assign o_busy     = r_busy;
  assign o_misalign = r_misalign;

endmodule
